bresenham_line_walker: RTL and testbench

//  Consumes one beam endpoint (x_end, y_end) produced by the beam-projection datapath.

---
 rtl/ram_pkg.sv | 38 +++
 rtl/bresenham_line_walker.sv | 99 +++++++++
 tb/tb_bresenham_line_walker.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared map-grid types and constants, plus the Bresenham step helper used by the
// line walker and intended for reuse by later scan-matching logic.
package ram_pkg;

  localparam int INDEX_W  = 6;
  localparam int ORIGIN_X = 32;
  localparam int ORIGIN_Y = 32;
  localparam int ERR_W    = INDEX_W + 2;

  typedef logic [INDEX_W-1:0]        index_t;
  typedef logic signed [ERR_W-1:0]   err_t;

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} walker_state_t;

  typedef struct packed {
    logic step_x;
    logic step_y;
    err_t err_next;
  } step_t;

  // Both tests use the pre-update 2*err so that a diagonal step is decided in one shot.
  function automatic step_t bresenham_step(input err_t err, input err_t dx, input err_t dy);
    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] dx_w;
    logic signed [ERR_W:0] dy_w;
    step_t s;
    e2   = {err, 1'b0};
    dx_w = dx;
    dy_w = dy;
    s.step_x   = (e2 >= dy_w);
    s.step_y   = (e2 <= dx_w);
    s.err_next = err;
    if (s.step_x) s.err_next = s.err_next + dy;
    if (s.step_y) s.err_next = s.err_next + dx;
    return s;
  endfunction

endpackage

// File: rtl/bresenham_line_walker.sv
// Walks the integer Bresenham line from the sensor origin cell to one beam endpoint,
// emitting free cells then the hit endpoint cell, one per accepted output beat.
module bresenham_line_walker #(
  parameter int INDEX_W  = ram_pkg::INDEX_W,
  parameter int ORIGIN_X = ram_pkg::ORIGIN_X,
  parameter int ORIGIN_Y = ram_pkg::ORIGIN_Y
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INDEX_W-1:0] x_end,
  input  logic [INDEX_W-1:0] y_end,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] x_cell,
  output logic [INDEX_W-1:0] y_cell,
  output logic               out_hit,
  output logic               out_last,
  output logic               busy
);
  import ram_pkg::*;

  localparam logic [INDEX_W-1:0] OX  = INDEX_W'(ORIGIN_X);
  localparam logic [INDEX_W-1:0] OY  = INDEX_W'(ORIGIN_Y);
  localparam logic [INDEX_W-1:0] ONE = INDEX_W'(1);

  walker_state_t      r_state;
  logic [INDEX_W-1:0] r_x, r_y, r_x_end, r_y_end;
  err_t               r_err, r_dx, r_dy;
  logic               r_sx_neg, r_sy_neg;

  err_t  w_ddx, w_ddy, w_adx, w_ady;
  logic  w_walk, w_last;
  step_t w_step;

  assign w_ddx  = err_t'(x_end) - err_t'(OX);
  assign w_ddy  = err_t'(y_end) - err_t'(OY);
  assign w_adx  = (w_ddx < 0) ? -w_ddx : w_ddx;
  assign w_ady  = (w_ddy < 0) ? -w_ddy : w_ddy;

  assign w_walk = (r_state == WALK);
  assign w_last = (r_x == r_x_end) && (r_y == r_y_end);
  assign w_step = bresenham_step(r_err, r_dx, r_dy);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = w_walk;
  assign busy      = w_walk;
  assign out_hit   = w_walk && w_last;
  assign out_last  = w_walk && w_last;
  assign x_cell    = r_x;
  assign y_cell    = r_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x      <= OX;
      r_y      <= OY;
      r_x_end  <= OX;
      r_y_end  <= OY;
      r_err    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state  <= WALK;
            r_x      <= OX;
            r_y      <= OY;
            r_x_end  <= x_end;
            r_y_end  <= y_end;
            r_dx     <= w_adx;
            r_dy     <= -w_ady;
            r_err    <= w_adx - w_ady;
            r_sx_neg <= (w_ddx < 0);
            r_sy_neg <= (w_ddy < 0);
          end
        end
        WALK: begin
          // Nothing moves without the output handshake, so stalled beats hold.
          if (out_ready) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              if (w_step.step_x) r_x <= r_sx_neg ? (r_x - ONE) : (r_x + ONE);
              if (w_step.step_y) r_y <= r_sy_neg ? (r_y - ONE) : (r_y + ONE);
              r_err <= w_step.err_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line_walker.sv
// Directed bench for the Bresenham line walker: expected cell sequences are hand-derived.
module tb_bresenham_line_walker;
  localparam int W = 6;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x_end = '0;
  logic [W-1:0] y_end = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] x_cell, y_cell;
  logic         out_hit, out_last, busy;

  int n_pass = 0;
  int n_total = 0;

  // Captured beats from the most recent ray.
  int         cap_n;
  int         cap_cycles;
  int         cap_stall_bad;
  bit         cap_timeout;
  logic [W-1:0] cap_x [16];
  logic [W-1:0] cap_y [16];
  logic         cap_hit [16];
  logic         cap_last [16];

  always #5 clock = ~clock;

  bresenham_line_walker dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_end(x_end), .y_end(y_end),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_cell(x_cell), .y_cell(y_cell),
    .out_hit(out_hit), .out_last(out_last),
    .busy(busy)
  );

  // Offer one endpoint; returns #1 after the accept edge.
  task automatic offer(input logic [W-1:0] xe, input logic [W-1:0] ye);
    in_valid = 1'b1;
    x_end    = xe;
    y_end    = ye;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Record handshaken beats under an out_ready pattern until the last beat or a cycle budget.
  task automatic capture(input logic [15:0] pat);
    bit done;
    bit prev_stall;
    logic [2*W+1:0] prev;
    done = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    cap_n = 0;
    cap_cycles = 0;
    cap_stall_bad = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      out_ready = pat[c % 16];
      if (out_valid && prev_stall && ({x_cell, y_cell, out_hit, out_last} !== prev))
        cap_stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev = {x_cell, y_cell, out_hit, out_last};
      if (out_valid && out_ready && cap_n < 16) begin
        cap_x[cap_n]    = x_cell;
        cap_y[cap_n]    = y_cell;
        cap_hit[cap_n]  = out_hit;
        cap_last[cap_n] = out_last;
        cap_n++;
        if (out_last) done = 1'b1;
      end
      cap_cycles++;
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    cap_timeout = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    n_total++;
    if ({in_ready, out_valid, busy, out_hit, out_last} !== 5'b10000) begin
      $display("FAIL reset_ctrl got %b want 10000", {in_ready, out_valid, busy, out_hit, out_last});
    end else n_pass++;
    n_total++;
    if (x_cell !== 6'd32 || y_cell !== 6'd32) begin
      $display("FAIL reset_cell got (%0d,%0d) want (32,32)", x_cell, y_cell);
    end else n_pass++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_horizontal();
    logic [W-1:0] ex [4] = '{6'd32, 6'd33, 6'd34, 6'd35};
    logic [W-1:0] ey [4] = '{6'd32, 6'd32, 6'd33, 6'd33};
    offer(6'd35, 6'd33);
    n_total++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL t1_first_beat valid=%b busy=%b in_ready=%b want 1 1 0", out_valid, busy, in_ready);
    end else n_pass++;
    capture(16'hFFFF);
    n_total++;
    if (cap_timeout || cap_n !== 4 || cap_cycles !== 4) begin
      $display("FAIL t1_count beats=%0d cycles=%0d timeout=%0d want 4 4 0", cap_n, cap_cycles, cap_timeout);
    end else n_pass++;
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_total++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== ey[i] || cap_hit[i] !== (i == 3) || cap_last[i] !== (i == 3)) begin
        $display("FAIL t1_beat%0d got (%0d,%0d) h%b l%b want (%0d,%0d) h%0d", i, cap_x[i], cap_y[i],
                 cap_hit[i], cap_last[i], ex[i], ey[i], (i == 3));
      end else n_pass++;
    end
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL t1_idle in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end else n_pass++;
  endtask

  task automatic test_vertical_ignore_in();
    logic [W-1:0] ey [4] = '{6'd32, 6'd31, 6'd30, 6'd29};
    offer(6'd32, 6'd29);
    // A competing endpoint held during the walk must be ignored.
    in_valid = 1'b1;
    x_end = 6'd40;
    y_end = 6'd40;
    capture(16'hFFFF);
    in_valid = 1'b0;
    n_total++;
    if (cap_timeout || cap_n !== 4) begin
      $display("FAIL t2_count beats=%0d timeout=%0d want 4 0", cap_n, cap_timeout);
    end else n_pass++;
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_total++;
      if (cap_x[i] !== 6'd32 || cap_y[i] !== ey[i] || cap_hit[i] !== (i == 3) || cap_last[i] !== (i == 3)) begin
        $display("FAIL t2_beat%0d got (%0d,%0d) h%b l%b want (32,%0d) h%0d", i, cap_x[i], cap_y[i],
                 cap_hit[i], cap_last[i], ey[i], (i == 3));
      end else n_pass++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_diagonal();
    logic [W-1:0] ex [4] = '{6'd32, 6'd31, 6'd30, 6'd29};
    logic [W-1:0] ey [4] = '{6'd32, 6'd33, 6'd34, 6'd35};
    offer(6'd29, 6'd35);
    capture(16'hFFFF);
    n_total++;
    if (cap_timeout || cap_n !== 4) begin
      $display("FAIL t3_count beats=%0d timeout=%0d want 4 0", cap_n, cap_timeout);
    end else n_pass++;
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_total++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== ey[i] || cap_hit[i] !== (i == 3)) begin
        $display("FAIL t3_beat%0d got (%0d,%0d) h%b want (%0d,%0d) h%0d", i, cap_x[i], cap_y[i],
                 cap_hit[i], ex[i], ey[i], (i == 3));
      end else n_pass++;
    end
  endtask

  task automatic test_origin();
    offer(6'd32, 6'd32);
    n_total++;
    if (out_valid !== 1'b1 || x_cell !== 6'd32 || y_cell !== 6'd32 || out_hit !== 1'b1 || out_last !== 1'b1) begin
      $display("FAIL t4_beat got v%b (%0d,%0d) h%b l%b want v1 (32,32) h1 l1", out_valid, x_cell, y_cell,
               out_hit, out_last);
    end else n_pass++;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL t4_after in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ex [4] = '{6'd32, 6'd33, 6'd34, 6'd35};
    logic [W-1:0] ey [4] = '{6'd32, 6'd32, 6'd33, 6'd33};
    offer(6'd35, 6'd33);
    capture(16'b1001_1001_1001_1001);
    n_total++;
    if (cap_timeout || cap_n !== 4) begin
      $display("FAIL t5_count beats=%0d timeout=%0d want 4 0", cap_n, cap_timeout);
    end else n_pass++;
    n_total++;
    if (cap_stall_bad !== 0) begin
      $display("FAIL t5_stall_hold changes=%0d want 0", cap_stall_bad);
    end else n_pass++;
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_total++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== ey[i] || cap_last[i] !== (i == 3)) begin
        $display("FAIL t5_beat%0d got (%0d,%0d) l%b want (%0d,%0d) l%0d", i, cap_x[i], cap_y[i],
                 cap_last[i], ex[i], ey[i], (i == 3));
      end else n_pass++;
    end
  endtask

  task automatic test_reset_midwalk();
    offer(6'd35, 6'd33);
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || x_cell !== 6'd34 || y_cell !== 6'd33) begin
      $display("FAIL t6_pre v%b (%0d,%0d) want v1 (34,33)", out_valid, x_cell, y_cell);
    end else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({out_valid, busy, in_ready, out_hit, out_last} !== 5'b00100 || x_cell !== 6'd32 || y_cell !== 6'd32) begin
      $display("FAIL t6_abort got v%b b%b r%b (%0d,%0d) want v0 b0 r1 (32,32)", out_valid, busy, in_ready,
               x_cell, y_cell);
    end else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    offer(6'd33, 6'd32);
    capture(16'hFFFF);
    n_total++;
    if (cap_timeout || cap_n !== 2) begin
      $display("FAIL t6_count beats=%0d timeout=%0d want 2 0", cap_n, cap_timeout);
    end else n_pass++;
    if (cap_n >= 2) begin
      n_total++;
      if (cap_x[0] !== 6'd32 || cap_y[0] !== 6'd32 || cap_hit[0] !== 1'b0 ||
          cap_x[1] !== 6'd33 || cap_y[1] !== 6'd32 || cap_hit[1] !== 1'b1) begin
        $display("FAIL t6_cells got (%0d,%0d)h%b (%0d,%0d)h%b want (32,32)h0 (33,32)h1", cap_x[0], cap_y[0],
                 cap_hit[0], cap_x[1], cap_y[1], cap_hit[1]);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical_ignore_in();
    test_diagonal();
    test_origin();
    test_backpressure();
    test_reset_midwalk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
